decode_q: RTL

DECODE_Q -- requirements
Module: decode_q

---
 rtl/decode_q.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_q.sv
// Decoded-instruction queue: canonical instructions are decoded as they are
// enqueued, and the head entry drives every output directly.
module decode_q #(
  parameter int DEPTH   = 4,
  parameter int JI_SEXT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            inst,
  input  logic                   in_bad,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   type_o,
  output logic [2:0]             unit,
  output logic [1:0]             op,
  output logic [5:0]             rd_rn,
  output logic [5:0]             rd2_rn,
  output logic [5:0]             rs1_rn,
  output logic [5:0]             rs2_rn,
  output logic [63:0]            imm_data,
  output logic [5:0]             r1_rn,
  output logic [5:0]             r2_rn,
  output logic                   bad,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic        typ;
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [5:0]  rd;
    logic [5:0]  rd2;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [63:0] imm;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic        bad;
  } entry_t;

  logic [2:0] f_unit;
  logic [1:0] f_op;
  logic [4:0] opc;
  logic       is_ji;
  logic       imm_signed;
  logic [6:0] ji_fill;
  logic       ld_rs1;
  logic       ld_rs1_rs2;
  logic       ld_rs1_rd;
  logic       unused_inst_hi;
  entry_t     dec_entry;

  assign f_unit = inst[60:58];
  assign f_op   = inst[57:56];
  assign opc    = inst[60:56];
  assign is_ji  = (inst[61:57] == 5'b11111);
  assign unused_inst_hi = ^inst[63:62];

  assign imm_signed = (opc[4:2] == 3'b000)
                    | ((opc[4:2] == 3'b001) & ~opc[0])
                    | (opc[4:3] == 2'b10)
                    | (opc[4:2] == 3'b110)
                    | (opc[4:1] == 4'b1110);

  assign ji_fill = (JI_SEXT != 0) ? {7{inst[55]}} : 7'b0;

  // Register-read classes; inst[61] separates R-type (0) from I-type (1).
  always_comb begin
    ld_rs1     = 1'b0;
    ld_rs1_rs2 = 1'b0;
    ld_rs1_rd  = 1'b0;
    if (!inst[61]) begin
      ld_rs1_rs2 = (f_unit < 3'd5) || ((f_unit == 3'd7) && (f_op == 2'd1));
      ld_rs1     = (f_unit == 3'd7) && f_op[1];
    end else begin
      ld_rs1    = (f_unit < 3'd5) || ((f_unit == 3'd5) && (f_op != 2'd0));
      ld_rs1_rd = (f_unit == 3'd6) || ((f_unit == 3'd7) && !f_op[1]);
    end
  end

  always_comb begin
    dec_entry      = '0;
    dec_entry.typ  = inst[61];
    dec_entry.unit = f_unit;
    dec_entry.op   = f_op;
    dec_entry.rd   = inst[55:50];
    dec_entry.rd2  = inst[49:44];
    dec_entry.rs1  = inst[43:38];
    dec_entry.rs2  = inst[37:32];
    dec_entry.bad  = in_bad;
    if (is_ji) begin
      dec_entry.imm = {ji_fill, inst[55:0], 1'b0};
    end else if (imm_signed) begin
      dec_entry.imm = {{32{inst[31]}}, inst[31:0]};
    end else begin
      dec_entry.imm = {32'b0, inst[31:0]};
    end
    // A flagged instruction must never request register reads.
    if (!in_bad) begin
      if (ld_rs1 || ld_rs1_rs2 || ld_rs1_rd) begin
        dec_entry.r1 = inst[43:38];
      end
      if (ld_rs1_rd) begin
        dec_entry.r2 = inst[55:50];
      end else if (ld_rs1_rs2) begin
        dec_entry.r2 = inst[37:32];
      end
    end
  end

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic          push;
  logic          pop;
  logic          push_en;

  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;
  assign push_en  = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= dec_entry;
    end
  end

  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign type_o    = head.typ;
  assign unit      = head.unit;
  assign op        = head.op;
  assign rd_rn     = head.rd;
  assign rd2_rn    = head.rd2;
  assign rs1_rn    = head.rs1;
  assign rs2_rn    = head.rs2;
  assign imm_data  = head.imm;
  assign r1_rn     = head.r1;
  assign r2_rn     = head.r2;
  assign bad       = head.bad;

endmodule
